ks_sub_pipe_32: RTL and testbench



---
 rtl/ks_pkg.sv | 22 ++
 rtl/ks_prefix_level.sv | 23 ++
 rtl/ks_sub_pipe_32.sv | 164 ++++++++++++++++
 tb/tb_ks_sub_pipe_32.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone subtractor.
package ks_pkg;

    localparam int unsigned KS_WIDTH  = 32;
    localparam int unsigned KS_LEVELS = 5;

    typedef logic [KS_WIDTH-1:0] ks_word_t;

    // Generate/propagate payload carried between pipeline stages
    typedef struct packed {
        ks_word_t g;
        ks_word_t p;
        ks_word_t p_raw;
        logic     a_sign;
        logic     b_sign;
    } ks_gp_t;

    function automatic int unsigned ks_span(input int unsigned level);
        return 32'd1 << level;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level: black cells at bits >= SPAN, pass-through below.
module ks_prefix_level #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPAN  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i >= int'(SPAN)) begin : g_black
            assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-int'(SPAN)]);
            assign p_out[i] = p_in[i] & p_in[i-int'(SPAN)];
        end else begin : g_pass
            // Prefix already complete here: G holds the final carry
            assign g_out[i] = g_in[i];
            assign p_out[i] = p_in[i];
        end
    end

endmodule

// File: rtl/ks_sub_pipe_32.sv
// Three-stage pipelined Kogge-Stone subtractor (a - b) with valid/ready handshake and flags.
// Define KS_SUB_SAT_EN to saturate diff to the signed range on overflow.
module ks_sub_pipe_32
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH  = KS_WIDTH,
    parameter int unsigned LEVELS = KS_LEVELS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             lt
);

    localparam int unsigned MSB       = WIDTH - 1;
    localparam int unsigned S2_LEVELS = 3;
    localparam int unsigned S3_LEVELS = LEVELS - S2_LEVELS;

    if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0) ||
        (LEVELS != $clog2(WIDTH))) begin : g_cfg_check
        $error("ks_sub_pipe_32: WIDTH must be a power of two in [8,64] with LEVELS = log2(WIDTH)");
    end

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] p_raw;
        logic             a_sign;
        logic             b_sign;
    } gp_t;

    // Final stage only needs carries and raw propagate
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p_raw;
        logic             a_sign;
        logic             b_sign;
    } res_t;

    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;
    gp_t  s1, s1_d, s2, s2_d;
    res_t s3, s3_d;

    assign rdy3      = ~v3 | out_ready;
    assign rdy2      = ~v2 | rdy3;
    assign rdy1      = ~v1 | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (rdy1) v1 <= in_valid;
            if (rdy2) v2 <= v1;
            if (rdy3) v3 <= v2;
        end
    end

    // Payload registers are not reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (in_valid && rdy1) s1 <= s1_d;
        if (v1 && rdy2)       s2 <= s2_d;
        if (v2 && rdy3)       s3 <= s3_d;
    end

    // Stage 1: a + ~b with carry-in 1 folded into g[0]
    logic [WIDTH-1:0] nb;
    always_comb begin
        nb            = ~b;
        s1_d.p        = a ^ nb;
        s1_d.g        = a & nb;
        s1_d.g[0]     = a[0] | nb[0];
        s1_d.p_raw    = a ^ nb;
        s1_d.a_sign   = a[MSB];
        s1_d.b_sign   = b[MSB];
    end

    logic [WIDTH-1:0] g_a [0:S2_LEVELS];
    logic [WIDTH-1:0] p_a [0:S2_LEVELS];
    assign g_a[0] = s1.g;
    assign p_a[0] = s1.p;

    for (genvar l = 0; l < int'(S2_LEVELS); l++) begin : g_s2_lvl
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (ks_span(unsigned'(l)))
        ) u_lvl (
            .g_in  (g_a[l]),
            .p_in  (p_a[l]),
            .g_out (g_a[l+1]),
            .p_out (p_a[l+1])
        );
    end

    always_comb begin
        s2_d.g      = g_a[S2_LEVELS];
        s2_d.p      = p_a[S2_LEVELS];
        s2_d.p_raw  = s1.p_raw;
        s2_d.a_sign = s1.a_sign;
        s2_d.b_sign = s1.b_sign;
    end

    logic [WIDTH-1:0] g_b [0:S3_LEVELS];
    logic [WIDTH-1:0] p_b [0:S3_LEVELS];
    assign g_b[0] = s2.g;
    assign p_b[0] = s2.p;

    for (genvar l = 0; l < int'(S3_LEVELS); l++) begin : g_s3_lvl
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (ks_span(unsigned'(l) + S2_LEVELS))
        ) u_lvl (
            .g_in  (g_b[l]),
            .p_in  (p_b[l]),
            .g_out (g_b[l+1]),
            .p_out (p_b[l+1])
        );
    end

    // Group propagate is dead after the last level
    logic unused_p_final;
    assign unused_p_final = ^p_b[S3_LEVELS];

    always_comb begin
        s3_d.g      = g_b[S3_LEVELS];
        s3_d.p_raw  = s2.p_raw;
        s3_d.a_sign = s2.a_sign;
        s3_d.b_sign = s2.b_sign;
    end

    // Sum and flags from the S3 registers, forced to 0 while no result is valid
    logic [WIDTH-1:0] sum, diff_res;
    logic             ovf_raw;

    assign sum     = s3.p_raw ^ {s3.g[WIDTH-2:0], 1'b1};
    assign ovf_raw = (s3.a_sign != s3.b_sign) && (sum[MSB] != s3.a_sign);

`ifdef KS_SUB_SAT_EN
    assign diff_res = !ovf_raw ? sum :
                      (s3.a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign diff_res = sum;
`endif

    assign diff   = v3 ? diff_res : '0;
    assign borrow = v3 & ~s3.g[MSB];
    assign ovf    = v3 & ovf_raw;
    assign zero   = v3 & (sum == '0);
    assign lt     = v3 & (sum[MSB] ^ ovf_raw);

endmodule

// File: tb/tb_ks_sub_pipe_32.sv
// Self-checking bench for ks_sub_pipe_32: directed cases, backpressure, reset, random traffic.
module tb_ks_sub_pipe_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        borrow, ovf, zero, lt;

    ks_sub_pipe_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          t;
    } op_t;

    op_t         q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          last_lat = 0;
    logic [35:0] last_res = '0;
    logic [35:0] held = '0;
    bit          stall_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {diff, borrow, ovf, zero, lt} from plain integer arithmetic
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        longint      sd;
        logic        o;
        logic [31:0] d;
        sd = longint'($signed(x)) - longint'($signed(y));
        o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        d  = x - y;
`ifdef KS_SUB_SAT_EN
        if (o) d = (sd > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {d, x < y, o, x == y, sd < 0};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every negedge, away from the active edge
    always @(negedge clk) begin
        op_t op;
        cyc++;
        if (!rst_n) begin
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_in_ready", 64'(in_ready), 64'(1));
            check("reset_outputs", 64'({diff, borrow, ovf, zero, lt}), 64'(0));
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_hold", 64'({diff, borrow, ovf, zero, lt}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    op = q.pop_front();
                    check("result", 64'({diff, borrow, ovf, zero, lt}), 64'(model(op.a, op.b)));
                    last_lat = cyc - op.t;
                    last_res = {diff, borrow, ovf, zero, lt};
                    n_out++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {diff, borrow, ovf, zero, lt};
            if (in_valid && in_ready) q.push_back('{a, b, cyc});
        end
    end

    // Single op into an idle pipe; checks latency and a hand-computed literal result
    task automatic do_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [35:0] exp);
        int start;
        start = n_out;
        @(posedge clk); #1;
        in_valid = 1'b1; a = xa; b = xb; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && n_out == start; k++) begin
            @(negedge clk); #1;
        end
        if (n_out == start) begin
            check({name, "_timeout"}, 64'(0), 64'(1));
        end else begin
            check({name, "_latency"}, 64'(last_lat), 64'(3));
            check({name, "_literal"}, 64'(last_res), 64'(exp));
        end
    endtask

    initial begin
        int start, sent, sent_at_low;
        bit saw_low;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // {diff, borrow, ovf, zero, lt}
        do_op("sub_5_3", 32'h5, 32'h3, {32'h0000_0002, 4'b0000});
        do_op("wrap_0_1", 32'h0, 32'h1, {32'hFFFF_FFFF, 4'b1001});
        do_op("equal", 32'h1234_5678, 32'h1234_5678, {32'h0000_0000, 4'b0010});
`ifdef KS_SUB_SAT_EN
        do_op("sat_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h7FFF_FFFF, 4'b1100});
        do_op("sat_neg", 32'h8000_0000, 32'h0000_0001, {32'h8000_0000, 4'b0101});
`else
        do_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 4'b0101});
        do_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, {32'h8000_0000, 4'b1100});
`endif

        // Backpressure: 10 back-to-back ops, consumer stalled for cycles 4-9
        start = n_out; sent = 0; saw_low = 1'b0; sent_at_low = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = (sent < 10);
            a = $urandom; b = $urandom;
            @(negedge clk); #1;
            if (in_valid && in_ready) sent++;
            if (!in_ready && !saw_low) begin
                saw_low = 1'b1;
                sent_at_low = sent;
            end
        end
        in_valid = 1'b0;
        check("bp_in_ready_fell", 64'(saw_low), 64'(1));
        check("bp_accepts_before_full", 64'(sent_at_low), 64'(4));
        check("bp_all_sent", 64'(sent), 64'(10));
        check("bp_all_received", 64'(n_out - start), 64'(10));

        // Reset with three ops in flight
        start = n_out;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("rst_async_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("rst_no_stale", 64'(n_out - start), 64'(0));
        do_op("post_reset", 32'h0000_0010, 32'h0000_0020, {32'hFFFF_FFF0, 4'b1001});

        // Random traffic with random valid/ready
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            a = pick(); b = pick();
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        #1 check("drain_empty", 64'(q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
